// File: rtl/sc_gamestatus_datapath.sv
// Frogger status datapath: executes the controller's active-low strobes and turns
// collision/arrival edges into the comparator and last-register status it polls.
module sc_gamestatus_datapath #(
  parameter int LIVES_INIT = 3,
  parameter int LIVES_W    = 2,
  parameter int LEVEL_MAX  = 4,
  parameter int LEVEL_W    = 3,
  parameter int HOUSES     = 5,
  parameter int HIDX_W     = 3
) (
  input  logic                SC_GAMESTATUS_CLOCK_50,
  input  logic                SC_GAMESTATUS_RESET_InHigh,
  input  logic                SC_GAMESTATUS_StartGame_InLow,
  input  logic                SC_GAMESTATUS_LifesSignal_InLow,
  input  logic                SC_GAMESTATUS_LoadLastRegister_InLow,
  input  logic                SC_GAMESTATUS_TransitionCounter1_InLow,
  input  logic                SC_GAMESTATUS_LoadGame_InLow,
  input  logic                SC_GAMESTATUS_clearPoint_InLow,
  input  logic                SC_GAMESTATUS_ClearLost_InLow,
  input  logic                SC_GAMESTATUS_Collision_InLow,
  input  logic                SC_GAMESTATUS_Arrive_InLow,
  input  logic [HIDX_W-1:0]   SC_GAMESTATUS_ArriveHouse_InBUS,
  output logic                SC_GAMESTATUS_LifesCounterComparator_OutLow,
  output logic                SC_GAMESTATUS_LevelCounterComparator_OutLow,
  output logic                SC_GAMESTATUS_MatrixComparator_OutLow,
  output logic [1:0]          SC_GAMESTATUS_LastRegister_OutBUS,
  output logic [LIVES_W-1:0]  SC_GAMESTATUS_Lives_OutBUS,
  output logic [LEVEL_W-1:0]  SC_GAMESTATUS_Level_OutBUS,
  output logic [HOUSES-1:0]   SC_GAMESTATUS_Houses_OutBUS
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_PEND_COL,
    ST_PEND_HOUSE,
    ST_OVER
  } state_t;

  localparam logic [LIVES_W-1:0] LivesInit = LIVES_W'(LIVES_INIT);
  localparam logic [LEVEL_W-1:0] LevelMax  = LEVEL_W'(LEVEL_MAX);
  localparam logic [HOUSES-1:0]  HouseOne  = HOUSES'(1);
  localparam logic [HOUSES-1:0]  AllHouses = '1;

  state_t              state_q, state_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [HOUSES-1:0]   bitmap_q, bitmap_d;
  logic [HIDX_W-1:0]   pendIdx_q, pendIdx_d;
  logic                collisionPrev_q, collisionPrev_d;
  logic                arrivePrev_q, arrivePrev_d;

  logic                lifesCmp_q;
  logic                levelCmp_q;
  logic                matrixCmp_q;
  logic [1:0]          lastReg_q;

  logic                colEvent;
  logic                arrEvent;
  logic                houseFree;

  // A completed row outranks a pending house so the controller sees level-complete first.
  function automatic logic [1:0] lastCode(input logic [HOUSES-1:0] bm, input state_t st);
    if (bm == AllHouses)
      return 2'b00;
    else if (st == ST_PEND_HOUSE)
      return 2'b10;
    else
      return 2'b01;
  endfunction

  assign colEvent = collisionPrev_q & ~SC_GAMESTATUS_Collision_InLow;
  assign arrEvent = arrivePrev_q & ~SC_GAMESTATUS_Arrive_InLow;

  always_comb begin
    houseFree = 1'b0;
    if (int'(SC_GAMESTATUS_ArriveHouse_InBUS) < HOUSES)
      houseFree = ~bitmap_q[SC_GAMESTATUS_ArriveHouse_InBUS];
  end

  always_comb begin
    state_d         = state_q;
    lives_d         = lives_q;
    level_d         = level_q;
    bitmap_d        = bitmap_q;
    pendIdx_d       = pendIdx_q;
    collisionPrev_d = SC_GAMESTATUS_Collision_InLow;
    arrivePrev_d    = SC_GAMESTATUS_Arrive_InLow;

    if (!SC_GAMESTATUS_StartGame_InLow) begin
      lives_d   = LivesInit;
      level_d   = '0;
      bitmap_d  = '0;
      pendIdx_d = '0;
      state_d   = ST_PLAY;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (colEvent) begin
            state_d = ST_PEND_COL;
          end else if (arrEvent) begin
            if (houseFree) begin
              pendIdx_d = SC_GAMESTATUS_ArriveHouse_InBUS;
              state_d   = ST_PEND_HOUSE;
            end else begin
              state_d = ST_PEND_COL;
            end
          end
        end
        ST_PEND_COL: begin
          if (!SC_GAMESTATUS_clearPoint_InLow)
            state_d = ST_PLAY;
        end
        ST_PEND_HOUSE: begin
          if (!SC_GAMESTATUS_LoadLastRegister_InLow)
            bitmap_d = bitmap_q | (HouseOne << pendIdx_q);
          if (!SC_GAMESTATUS_clearPoint_InLow) begin
            pendIdx_d = '0;
            state_d   = ST_PLAY;
          end
        end
        default: ;
      endcase

      if (!SC_GAMESTATUS_LifesSignal_InLow && lives_q != '0)
        lives_d = lives_q - 1'b1;
      if (!SC_GAMESTATUS_TransitionCounter1_InLow && level_q != LevelMax)
        level_d = level_q + 1'b1;

      // Strobe overrides below are ordered so that ClearLost always has the last word.
      if (!SC_GAMESTATUS_LoadGame_InLow) begin
        bitmap_d  = '0;
        pendIdx_d = '0;
        if (state_q != ST_OVER)
          state_d = ST_PLAY;
      end
      if (!SC_GAMESTATUS_ClearLost_InLow)
        state_d = ST_OVER;
    end
  end

  always_ff @(posedge SC_GAMESTATUS_CLOCK_50) begin
    if (SC_GAMESTATUS_RESET_InHigh) begin
      state_q         <= ST_IDLE;
      lives_q         <= LivesInit;
      level_q         <= '0;
      bitmap_q        <= '0;
      pendIdx_q       <= '0;
      collisionPrev_q <= 1'b1;
      arrivePrev_q    <= 1'b1;
      lifesCmp_q      <= 1'b1;
      levelCmp_q      <= 1'b1;
      matrixCmp_q     <= 1'b1;
      lastReg_q       <= 2'b01;
    end else begin
      state_q         <= state_d;
      lives_q         <= lives_d;
      level_q         <= level_d;
      bitmap_q        <= bitmap_d;
      pendIdx_q       <= pendIdx_d;
      collisionPrev_q <= collisionPrev_d;
      arrivePrev_q    <= arrivePrev_d;
      lifesCmp_q      <= (lives_d != '0);
      levelCmp_q      <= (level_d != LevelMax);
      matrixCmp_q     <= (state_d != ST_PEND_COL);
      lastReg_q       <= lastCode(bitmap_d, state_d);
    end
  end

  assign SC_GAMESTATUS_LifesCounterComparator_OutLow = lifesCmp_q;
  assign SC_GAMESTATUS_LevelCounterComparator_OutLow = levelCmp_q;
  assign SC_GAMESTATUS_MatrixComparator_OutLow       = matrixCmp_q;
  assign SC_GAMESTATUS_LastRegister_OutBUS           = lastReg_q;
  assign SC_GAMESTATUS_Lives_OutBUS                  = lives_q;
  assign SC_GAMESTATUS_Level_OutBUS                  = level_q;
  assign SC_GAMESTATUS_Houses_OutBUS                 = bitmap_q;

endmodule

// File: tb/tb_sc_gamestatus_datapath.sv
// Bench for sc_gamestatus_datapath: directed game sequences with literal expectations,
// then randomized strobes/events compared every cycle against a behavioural model.
module tb_sc_gamestatus_datapath;

  localparam int LIVES_INIT = 3;
  localparam int LIVES_W    = 2;
  localparam int LEVEL_MAX  = 4;
  localparam int LEVEL_W    = 3;
  localparam int HOUSES     = 5;
  localparam int HIDX_W     = 3;

  // Strobe vector order: start, lifes, loadLast, trans, loadGame, clearPoint, clearLost
  localparam logic [6:0] NONE       = 7'b1111111;
  localparam logic [6:0] S_START    = 7'b0111111;
  localparam logic [6:0] S_LIFES    = 7'b1011111;
  localparam logic [6:0] S_LOADLAST = 7'b1101111;
  localparam logic [6:0] S_TRANS    = 7'b1110111;
  localparam logic [6:0] S_LOADGAME = 7'b1111011;
  localparam logic [6:0] S_CLRPT    = 7'b1111101;
  localparam logic [6:0] S_CLRLOST  = 7'b1111110;

  logic clock;
  logic reset;
  logic startN, lifesN, loadLastN, transN, loadGameN, clearPointN, clearLostN;
  logic collisionN, arriveN;
  logic [HIDX_W-1:0] houseIdx;

  logic              lifesCmp, levelCmp, matrixCmp;
  logic [1:0]        lastReg;
  logic [LIVES_W-1:0] livesOut;
  logic [LEVEL_W-1:0] levelOut;
  logic [HOUSES-1:0]  housesOut;

  int checkCount = 0;
  int errorCount = 0;
  bit checkEn = 0;

  // Reference model: game progress kept as plain integers and flags
  int mLives, mLevel, mPendIdx;
  bit mOcc[HOUSES];
  bit mStarted, mOver, mColPend, mHousePend;
  bit mPrevCol, mPrevArr;

  sc_gamestatus_datapath #(
    .LIVES_INIT(LIVES_INIT), .LIVES_W(LIVES_W), .LEVEL_MAX(LEVEL_MAX),
    .LEVEL_W(LEVEL_W), .HOUSES(HOUSES), .HIDX_W(HIDX_W)
  ) dut (
    .SC_GAMESTATUS_CLOCK_50                      (clock),
    .SC_GAMESTATUS_RESET_InHigh                  (reset),
    .SC_GAMESTATUS_StartGame_InLow               (startN),
    .SC_GAMESTATUS_LifesSignal_InLow             (lifesN),
    .SC_GAMESTATUS_LoadLastRegister_InLow        (loadLastN),
    .SC_GAMESTATUS_TransitionCounter1_InLow      (transN),
    .SC_GAMESTATUS_LoadGame_InLow                (loadGameN),
    .SC_GAMESTATUS_clearPoint_InLow              (clearPointN),
    .SC_GAMESTATUS_ClearLost_InLow               (clearLostN),
    .SC_GAMESTATUS_Collision_InLow               (collisionN),
    .SC_GAMESTATUS_Arrive_InLow                  (arriveN),
    .SC_GAMESTATUS_ArriveHouse_InBUS             (houseIdx),
    .SC_GAMESTATUS_LifesCounterComparator_OutLow (lifesCmp),
    .SC_GAMESTATUS_LevelCounterComparator_OutLow (levelCmp),
    .SC_GAMESTATUS_MatrixComparator_OutLow       (matrixCmp),
    .SC_GAMESTATUS_LastRegister_OutBUS           (lastReg),
    .SC_GAMESTATUS_Lives_OutBUS                  (livesOut),
    .SC_GAMESTATUS_Level_OutBUS                  (levelOut),
    .SC_GAMESTATUS_Houses_OutBUS                 (housesOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int expHouses();
    int v = 0;
    for (int i = 0; i < HOUSES; i++) if (mOcc[i]) v += (1 << i);
    return v;
  endfunction

  function automatic int expLast();
    if (expHouses() == (1 << HOUSES) - 1) return 0;
    if (mHousePend) return 2;
    return 1;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic modelStep();
    bit colEv, arrEv, playing, nextCol, nextHouse;
    if (reset) begin
      mLives = LIVES_INIT; mLevel = 0; mPendIdx = 0;
      for (int i = 0; i < HOUSES; i++) mOcc[i] = 0;
      mStarted = 0; mOver = 0; mColPend = 0; mHousePend = 0;
      mPrevCol = 1; mPrevArr = 1;
      return;
    end
    colEv = mPrevCol && !collisionN;
    arrEv = mPrevArr && !arriveN;
    mPrevCol = collisionN;
    mPrevArr = arriveN;
    if (!startN) begin
      mLives = LIVES_INIT; mLevel = 0;
      for (int i = 0; i < HOUSES; i++) mOcc[i] = 0;
      mStarted = 1; mOver = 0; mColPend = 0; mHousePend = 0;
      return;
    end
    playing   = mStarted && !mOver && !mColPend && !mHousePend;
    nextCol   = mColPend;
    nextHouse = mHousePend;
    if (playing && colEv) nextCol = 1;
    else if (playing && arrEv) begin
      if (int'(houseIdx) < HOUSES && !mOcc[houseIdx]) begin
        nextHouse = 1;
        mPendIdx  = int'(houseIdx);
      end else nextCol = 1;
    end
    if (mColPend && !clearPointN) nextCol = 0;
    if (mHousePend && !loadLastN) mOcc[mPendIdx] = 1;
    if (mHousePend && !clearPointN) nextHouse = 0;
    if (!lifesN && mLives > 0) mLives--;
    if (!transN && mLevel < LEVEL_MAX) mLevel++;
    if (!loadGameN) begin
      for (int i = 0; i < HOUSES; i++) mOcc[i] = 0;
      nextHouse = 0;
      if (!mOver) begin mStarted = 1; nextCol = 0; end
    end
    if (!clearLostN) begin mOver = 1; nextCol = 0; nextHouse = 0; end
    mColPend   = nextCol;
    mHousePend = nextHouse;
  endtask

  // Called at a falling edge; drives one cycle of inputs and returns at the next falling edge
  task automatic applyStimulus(input logic [6:0] strobes, input logic colN, input logic arrN,
                               input logic [HIDX_W-1:0] idx);
    {startN, lifesN, loadLastN, transN, loadGameN, clearPointN, clearLostN} = strobes;
    collisionN = colN;
    arriveN    = arrN;
    houseIdx   = idx;
    @(posedge clock);
    modelStep();
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("lifesCmp",  int'(lifesCmp),  (mLives != 0) ? 1 : 0);
      checkOutput("levelCmp",  int'(levelCmp),  (mLevel != LEVEL_MAX) ? 1 : 0);
      checkOutput("matrixCmp", int'(matrixCmp), mColPend ? 0 : 1);
      checkOutput("lastReg",   int'(lastReg),   expLast());
      checkOutput("lives",     int'(livesOut),  mLives);
      checkOutput("level",     int'(levelOut),  mLevel);
      checkOutput("houses",    int'(housesOut), expHouses());
    end
  end

  initial begin
    logic [6:0] strobes;
    logic [HIDX_W-1:0] fillIdx [4];
    fillIdx = '{3'd0, 3'd1, 3'd3, 3'd4};
    reset = 1'b1;
    collisionN = 1'b1;
    arriveN = 1'b1;
    houseIdx = '0;
    {startN, lifesN, loadLastN, transN, loadGameN, clearPointN, clearLostN} = NONE;
    @(negedge clock);
    applyStimulus(NONE, 1, 1, 0);
    checkEn = 1;
    applyStimulus(NONE, 1, 1, 0);
    checkOutput("reset lastReg", int'(lastReg), 1);
    checkOutput("reset lives", int'(livesOut), 3);
    reset = 1'b0;

    applyStimulus(S_START, 1, 1, 0);
    checkOutput("start lives", int'(livesOut), 3);
    checkOutput("start houses", int'(housesOut), 0);
    checkOutput("start matrix", int'(matrixCmp), 1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(NONE, 0, 1, 0);
      checkOutput("held collision matrix", int'(matrixCmp), 0);
    end
    applyStimulus(S_LIFES & S_CLRPT, 1, 1, 0);
    checkOutput("life lost lives", int'(livesOut), 2);
    checkOutput("life lost matrix", int'(matrixCmp), 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(NONE, 0, 1, 0);
      applyStimulus(S_LIFES & S_CLRPT, 1, 1, 0);
    end
    checkOutput("no lives", int'(livesOut), 0);
    checkOutput("no lives cmp", int'(lifesCmp), 0);

    applyStimulus(NONE, 1, 0, 2);
    checkOutput("house pending lastReg", int'(lastReg), 2);
    applyStimulus(S_LOADLAST & S_CLRPT, 1, 1, 2);
    checkOutput("house 2 bitmap", int'(housesOut), 5'b00100);
    checkOutput("house 2 lastReg", int'(lastReg), 1);
    applyStimulus(NONE, 1, 0, 2);
    checkOutput("occupied house matrix", int'(matrixCmp), 0);
    applyStimulus(S_CLRPT, 1, 1, 0);

    foreach (fillIdx[k]) begin
      applyStimulus(NONE, 1, 0, fillIdx[k]);
      applyStimulus(S_LOADLAST & S_CLRPT, 1, 1, fillIdx[k]);
    end
    checkOutput("full row bitmap", int'(housesOut), 5'b11111);
    checkOutput("full row lastReg", int'(lastReg), 0);

    for (int lv = 1; lv <= 4; lv++) begin
      applyStimulus(S_TRANS, 1, 1, 0);
      applyStimulus(S_LOADGAME & S_CLRPT, 1, 1, 0);
      checkOutput("next level", int'(levelOut), lv);
      checkOutput("next level houses", int'(housesOut), 0);
      checkOutput("next level lastReg", int'(lastReg), 1);
    end
    checkOutput("max level cmp", int'(levelCmp), 0);
    applyStimulus(S_TRANS, 1, 1, 0);
    checkOutput("level saturate", int'(levelOut), 4);

    applyStimulus(NONE, 0, 0, 0);
    checkOutput("col+arr matrix", int'(matrixCmp), 0);
    checkOutput("col+arr lastReg", int'(lastReg), 1);
    applyStimulus(S_CLRLOST, 1, 1, 0);
    checkOutput("over matrix", int'(matrixCmp), 1);
    applyStimulus(NONE, 0, 0, 1);
    applyStimulus(NONE, 1, 1, 1);
    applyStimulus(NONE, 1, 0, 1);
    checkOutput("over ignores matrix", int'(matrixCmp), 1);
    checkOutput("over ignores lastReg", int'(lastReg), 1);
    applyStimulus(S_START, 1, 1, 0);
    checkOutput("restart lives", int'(livesOut), 3);
    checkOutput("restart level", int'(levelOut), 0);
    checkOutput("restart levelCmp", int'(levelCmp), 1);

    applyStimulus(S_LIFES & S_TRANS, 1, 1, 0);
    applyStimulus(NONE, 1, 0, 1);
    applyStimulus(S_LOADLAST & S_CLRPT, 1, 1, 1);
    checkOutput("partial bitmap", int'(housesOut), 5'b00010);
    applyStimulus(NONE, 1, 0, 3);
    checkOutput("pre-reset lastReg", int'(lastReg), 2);
    reset = 1'b1;
    applyStimulus(NONE, 1, 1, 0);
    reset = 1'b0;
    checkOutput("mid-game reset lives", int'(livesOut), 3);
    checkOutput("mid-game reset level", int'(levelOut), 0);
    checkOutput("mid-game reset houses", int'(housesOut), 0);
    checkOutput("mid-game reset lastReg", int'(lastReg), 1);

    for (int c = 0; c < 3000; c++) begin
      strobes = NONE;
      if ($urandom_range(0, 39) == 0) strobes[6] = 1'b0;
      if ($urandom_range(0, 7) == 0)  strobes[5] = 1'b0;
      if ($urandom_range(0, 3) == 0)  strobes[4] = 1'b0;
      if ($urandom_range(0, 9) == 0)  strobes[3] = 1'b0;
      if ($urandom_range(0, 14) == 0) strobes[2] = 1'b0;
      if ($urandom_range(0, 3) == 0)  strobes[1] = 1'b0;
      if ($urandom_range(0, 59) == 0) strobes[0] = 1'b0;
      reset = ($urandom_range(0, 199) == 0);
      applyStimulus(strobes,
                    ($urandom_range(0, 3) == 0) ? ~collisionN : collisionN,
                    ($urandom_range(0, 3) == 0) ? ~arriveN : arriveN,
                    HIDX_W'($urandom_range(0, 7)));
    end
    reset = 1'b0;

    checkEn = 0;
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/sc_gamestatus_datapath.md
Name: sc_gamestatus_datapath

Overview:
Status datapath that answers the Frogger game controller. It executes the controller's active-low command strobes: start, lose life, load house, next level, load game, clear point and clear lost. It also turns raw play events (frog collision, frog arrival at a top-row house) into the status signals the controller polls each check cycle: lives comparator, level comparator, matrix comparator and the 2-bit last-register bus. It sits between the frog/obstacle matrix logic and the game controller.

Parameters:
LIVES_INIT, 3, lives loaded on start
LIVES_W, 2, lives counter width
LEVEL_MAX, 4, level value that means the game is won
LEVEL_W, 3, level counter width
HOUSES, 5, number of top-row houses (bitmap width)
HIDX_W, 3, house index width

Ports:
SC_GAMESTATUS_CLOCK_50  in  1  system clock
SC_GAMESTATUS_RESET_InHigh  in  1  reset; the only clock is SC_GAMESTATUS_CLOCK_50, and the reset is synchronous and active-high
SC_GAMESTATUS_StartGame_InLow  in  1  start or restart game
SC_GAMESTATUS_LifesSignal_InLow  in  1  decrement lives
SC_GAMESTATUS_LoadLastRegister_InLow  in  1  commit pending house
SC_GAMESTATUS_TransitionCounter1_InLow  in  1  increment level
SC_GAMESTATUS_LoadGame_InLow  in  1  new-level load: clear house bitmap
SC_GAMESTATUS_clearPoint_InLow  in  1  clear pending event
SC_GAMESTATUS_ClearLost_InLow  in  1  end of game: freeze play
SC_GAMESTATUS_Collision_InLow  in  1  frog overlaps obstacle (level signal)
SC_GAMESTATUS_Arrive_InLow  in  1  frog in top row (level signal)
SC_GAMESTATUS_ArriveHouse_InBUS  in  HIDX_W  house index, valid with Arrive
SC_GAMESTATUS_LifesCounterComparator_OutLow  out  1  low when lives==0
SC_GAMESTATUS_LevelCounterComparator_OutLow  out  1  low when level==LEVEL_MAX
SC_GAMESTATUS_MatrixComparator_OutLow  out  1  low while a collision is pending
SC_GAMESTATUS_LastRegister_OutBUS  out  2  house status code
SC_GAMESTATUS_Lives_OutBUS  out  LIVES_W  lives count
SC_GAMESTATUS_Level_OutBUS  out  LEVEL_W  level count
SC_GAMESTATUS_Houses_OutBUS  out  HOUSES  occupied-house bitmap

Behaviour:
- Reset (sync, wins over all inputs):
  - state=IDLE; lives=LIVES_INIT; level=0; bitmap=0; pending index=0.
  - Edge-detect previous-value registers = 1.
  - Outputs: LifesCmp=1, LevelCmp=1, MatrixCmp=1, LastRegister=2'b01.
- Event detection: Collision and Arrive are sampled each cycle. An event is a 1-to-0 transition only (prev=1, now=0). Holding a level low produces one event.
- FSM states:
  - IDLE: events ignored. StartGame low -> PLAY.
  - PLAY:
    - Collision event -> PEND_COL.
    - Arrive event, index < HOUSES and bitmap[index]==0 -> latch index -> PEND_HOUSE.
    - Arrive event, index >= HOUSES or house already occupied -> PEND_COL (counts as collision).
    - Collision and Arrive events in the same cycle: collision wins, arrival dropped.
  - PEND_COL: MatrixCmp=0. clearPoint low -> PLAY. Further events ignored.
  - PEND_HOUSE: LastRegister=2'b10. LoadLastRegister low -> set bitmap[index]. clearPoint low -> PLAY. Both strobes in the same cycle are allowed and expected. Further events ignored.
  - OVER: entered from any state on ClearLost low. Events ignored. StartGame low -> PLAY.
- StartGame low, from any state except during reset:
  - lives=LIVES_INIT, level=0, bitmap=0, pending cleared, edge registers reloaded with current inputs, state=PLAY.
  - Overrides every other strobe in the same cycle.
- Counter strobes (each acts once per low cycle, independent of FSM state):
  - LifesSignal low -> lives-1, saturating at 0.
  - TransitionCounter1 low -> level+1, saturating at LEVEL_MAX.
  - LoadGame low -> bitmap=0, pending cleared, state=PLAY unless OVER.
- LastRegister encoding (combinational from registers), priority top-down:
  - bitmap all ones -> 2'b00 (level complete).
  - PEND_HOUSE -> 2'b10.
  - otherwise -> 2'b01.
  - 2'b11 is never driven.
- Status latency: all status outputs are functions of registers only. A strobe at edge N is visible after edge N. The controller's check state one cycle later sees the updated value.
- Lose-life sequence: LifesSignal and clearPoint low in the same cycle -> lives decremented and MatrixCmp returns to 1 together. If lives reaches 0, LifesCmp=0 on the next cycle.
- House sequence: LoadLastRegister and clearPoint low together; the fifth house commit drives LastRegister=2'b00 on the next cycle.
- Next-level sequence: TransitionCounter1 low, then on the next cycle LoadGame and clearPoint low -> level+1, bitmap cleared, LastRegister=2'b01.

Test Plan:
- Reset, then StartGame low 1 cycle -> lives=3, level=0, Houses=5'b00000, LastRegister=2'b01, all comparators 1.
- In PLAY, drive Collision low for 10 cycles -> MatrixCmp=0 starting the next cycle; one event only. LifesSignal and clearPoint low 1 cycle -> lives=2, MatrixCmp=1. Repeat twice more -> lives=0, LifesCmp=0.
- Arrive low with index 2 -> LastRegister=2'b10. LoadLastRegister and clearPoint low -> Houses=5'b00100, LastRegister=2'b01. Arrive again at index 2 -> MatrixCmp=0 (occupied house).
- Fill houses 0..4 -> LastRegister=2'b00. TransitionCounter1 low, then LoadGame and clearPoint low -> level=1, Houses=0, LastRegister=2'b01. Repeat until level=4 -> LevelCmp=0; a further increment holds 4.
- Collision and Arrive falling in the same cycle -> MatrixCmp=0 and LastRegister stays 2'b01. ClearLost low -> OVER; later events cause no change. StartGame low -> full reload.
- Assert Reset for 1 cycle mid-PEND_HOUSE with the bitmap partly filled -> all registers return to reset values on the next edge and LastRegister=2'b01.
